// File: rtl/button_event_queue_pkg.sv
// Shared constants and types for the button event queue.
// Holds YES/NO flags and the 8-bit event code type.
package button_event_queue_pkg;

  localparam logic YES = 1'b1;
  localparam logic NO  = 1'b0;

  typedef logic [7:0] code_t;

endpackage

// File: rtl/event_fifo.sv
// Show-ahead event FIFO, 8-bit codes, DEPTH entries.
// Ports: clk, reset_low, push/push_data, pop/pop_data, full, empty, count.
module event_fifo
  import button_event_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_low,
  input  logic          push,
  input  code_t         push_data,
  input  logic          pop,
  output code_t         pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  // Pointers carry one extra wrap bit so that
  // full and empty are never ambiguous.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] fill;
  logic        do_push;
  logic        do_pop;

  code_t mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Illegal requests are dropped here, not upstream.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign fill  = wr_ptr - rd_ptr;
  assign count = CW'(fill);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/button_event_queue.sv
// Round-robin button arbiter feeding an event FIFO.
// Ports: btn_valid/btn_ready in, out_valid/out_data/out_ready out, count.
module button_event_queue
  import button_event_queue_pkg::*;
#(
  parameter int    BUTTONS   = 4,
  parameter int    DEPTH     = 4,
  parameter code_t CODE_BASE = 8'h31,
  localparam int   CW = $clog2(DEPTH + 1),
  localparam int   IW = (BUTTONS > 1) ? $clog2(BUTTONS) : 1
) (
  input  logic               clk,
  input  logic               reset_low,
  input  logic [BUTTONS-1:0] btn_valid,
  output logic [BUTTONS-1:0] btn_ready,
  output logic               out_valid,
  output code_t              out_data,
  input  logic               out_ready,
  output logic [CW-1:0]      count
);

  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      grant_idx;
  logic               found;
  logic [BUTTONS-1:0] grant_vec;
  logic               accept;
  logic               full;
  logic               empty;
  code_t              push_data;

  // Two passes give the wrapped upward search:
  // indices above last_grant first, then the rest.
  always_comb begin
    found     = NO;
    grant_idx = '0;
    for (int i = 0; i < BUTTONS; i++) begin
      if (!found && btn_valid[i] &&
          i > int'(last_grant)) begin
        found     = YES;
        grant_idx = IW'(i);
      end
    end
    for (int i = 0; i < BUTTONS; i++) begin
      if (!found && btn_valid[i] &&
          i <= int'(last_grant)) begin
        found     = YES;
        grant_idx = IW'(i);
      end
    end
  end

  // No grant while full, even if a pop is due.
  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < BUTTONS; i++) begin
      grant_vec[i] = found && (i == int'(grant_idx));
    end
  end

  assign btn_ready = grant_vec &
                     {BUTTONS{~full & reset_low}};
  assign accept    = |(btn_valid & btn_ready);
  assign push_data = CODE_BASE + code_t'(grant_idx);

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      last_grant <= IW'(BUTTONS - 1);
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

  event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_low (reset_low),
    .push      (accept),
    .push_data (push_data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign out_valid = ~empty;

endmodule

// File: tb/tb_button_event_queue.sv
// Randomized scoreboard bench for button_event_queue.
// Reference model: pending set, round-robin pick, code queue.
module tb_button_event_queue;

  localparam int B  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
  localparam logic [7:0] BASE = 8'h31;

  logic          clk = 1'b0;
  logic          reset_low = 1'b0;
  logic [B-1:0]  btn_valid = '0;
  logic [B-1:0]  btn_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb[$];
  logic [B-1:0] pend = '0;
  int           mcount = 0;
  int           mlast = B - 1;

  always #5 clk = ~clk;

  button_event_queue #(
    .BUTTONS   (B),
    .DEPTH     (D),
    .CODE_BASE (BASE)
  ) dut (
    .clk       (clk),
    .reset_low (reset_low),
    .btn_valid (btn_valid),
    .btn_ready (btn_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Next pending button after mlast, wrapping.
  function automatic int pick();
    for (int k = 1; k <= B; k++) begin
      int i;
      i = (mlast + k) % B;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic step(input logic [B-1:0] add,
                      input int press_pct,
                      input int ready_pct);
    int g;
    logic [B-1:0] er;
    bit pop;
    @(negedge clk);
    pend = pend | add;
    for (int i = 0; i < B; i++) begin
      if (!pend[i] &&
          $urandom_range(99) < press_pct)
        pend[i] = 1'b1;
    end
    btn_valid = pend;
    out_ready = ($urandom_range(99) < ready_pct);
    #1;
    g  = (mcount == D) ? -1 : pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("btn_ready", int'(btn_ready), int'(er));
    chk("count", int'(count), mcount);
    chk("out_valid", int'(out_valid),
        int'(mcount != 0));
    pop = out_ready && (mcount != 0);
    if (g >= 0) begin
      sb.push_back(BASE + 8'(g));
      pend[g] = 1'b0;
      mlast = g;
      mcount++;
    end
    if (pop) mcount--;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset_low = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_btn_ready", int'(btn_ready), 0);
    sb.delete();
    mcount = 0;
    mlast = B - 1;
    @(posedge clk);
    #2 reset_low = 1'b1;
  endtask

  // Monitor: compare each output transfer with the
  // oldest expected code.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_low && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data got %0h want none",
                   out_data);
        end else begin
          chk("out_data", int'(out_data),
              int'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    btn_valid = '1;
    #12;
    chk("rst0_count", int'(count), 0);
    chk("rst0_out_valid", int'(out_valid), 0);
    chk("rst0_btn_ready", int'(btn_ready), 0);
    btn_valid = '0;
    @(posedge clk);
    #2 reset_low = 1'b1;

    // Single press, no drain, then round robin.
    step(4'b0001, 0, 0);
    step('0, 0, 0);
    chk("first_code", int'(out_data), 'h31);
    step('0, 0, 100);
    for (int n = 0; n < 6; n++) step('1, 0, 100);
    // Fill past full, then one pop cycle.
    for (int n = 0; n < 8; n++) step('1, 0, 0);
    step('1, 0, 100);
    step('1, 0, 0);
    step('0, 0, 100);
    // Mid-operation reset with a partly full queue.
    step('0, 0, 100);
    step(4'b0111, 0, 0);
    step('0, 0, 0);
    step('0, 0, 0);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step('0, $urandom_range(10, 70),
           $urandom_range(10, 90));
      if (n == 200) do_reset();
    end
    for (int n = 0; n < 10; n++) step('0, 0, 100);
    #5;
    chk("drained", sb.size(), mcount);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
